// File: rtl/pe_cfg_seq.sv
// Configuration sequencer: parses header/payload words from an upstream stream
// and drives the valid-tagged configure ports of three processing elements.
module pe_cfg_seq #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              cfg_in_valid,
    input  logic [DATA_W-1:0] cfg_in_data,
    output logic              cfg_in_ready,
    output logic [DATA_W:0]   PE0_Configure_Inport,
    output logic [DATA_W:0]   PE1_Configure_Inport,
    output logic [DATA_W:0]   PE2_Configure_Inport,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [15:0]       words_total
);

    // Idle counter only has to reach TIMEOUT-1; the next empty cycle is the timeout.
    localparam int unsigned      CNT_W     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HDR,
        S_PAY,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              w_ready;
    logic              w_xfer;
    logic              w_pay_xfer;
    logic              w_start_acc;
    logic              w_timeout;
    logic [7:0]        w_hdr_cnt;
    logic [1:0]        w_hdr_dst;
    logic [7:0]        r_remain;
    logic [1:0]        r_dst;
    logic [CNT_W-1:0]  r_idle_cnt;
    logic              r_err;
    logic [15:0]       r_words;
    logic [DATA_W:0]   r_pe [3];

    assign w_hdr_cnt   = cfg_in_data[31:24];
    assign w_hdr_dst   = cfg_in_data[1:0];
    assign w_ready     = (r_state == S_HDR) || (r_state == S_PAY);
    assign w_xfer      = cfg_in_valid & w_ready;
    assign w_pay_xfer  = w_xfer && (r_state == S_PAY);
    assign w_start_acc = start && (r_state == S_IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_timeout = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start) w_next = S_HDR;
            end
            S_HDR: begin
                if (w_xfer) w_next = (w_hdr_cnt == 8'd0) ? S_DONE : S_PAY;
            end
            S_PAY: begin
                if (w_xfer) begin
                    if (r_remain == 8'd1) w_next = S_HDR;
                end else if (r_idle_cnt == IDLE_LAST) begin
                    w_timeout = 1'b1;
                    w_next    = S_IDLE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_remain   <= '0;
            r_dst      <= '0;
            r_idle_cnt <= '0;
            r_err      <= 1'b0;
            r_words    <= '0;
            for (int unsigned k = 0; k < 3; k++) begin
                r_pe[k] <= '0;
            end
        end else begin
            if (r_state == S_HDR && w_xfer) begin
                r_remain <= w_hdr_cnt;
                r_dst    <= w_hdr_dst;
            end else if (w_pay_xfer) begin
                r_remain <= r_remain - 8'd1;
            end

            r_idle_cnt <= (r_state == S_PAY && !w_xfer) ? r_idle_cnt + 1'b1 : '0;

            if (w_start_acc) begin
                r_err <= 1'b0;
            end else if (w_timeout) begin
                r_err <= 1'b1;
            end

            if (w_start_acc) begin
                r_words <= '0;
            end else if (w_pay_xfer && r_words != 16'hFFFF) begin
                r_words <= r_words + 16'd1;
            end

            // Valid is a one-cycle beat; payload bits hold until overwritten.
            for (int unsigned k = 0; k < 3; k++) begin
                r_pe[k][DATA_W] <= 1'b0;
                if (w_pay_xfer && (r_dst == 2'd3 || r_dst == 2'(k))) begin
                    r_pe[k] <= {1'b1, cfg_in_data};
                end
            end
        end
    end

    assign cfg_in_ready         = w_ready;
    assign busy                 = (r_state != S_IDLE);
    assign done                 = (r_state == S_DONE);
    assign err                  = r_err;
    assign words_total          = r_words;
    assign PE0_Configure_Inport = r_pe[0];
    assign PE1_Configure_Inport = r_pe[1];
    assign PE2_Configure_Inport = r_pe[2];

endmodule

// File: doc/pe_cfg_seq.md
PE_CFG_SEQ -- requirements
Module: pe_cfg_seq

Interface
REQ-001 Parameter DATA_W, 32, configuration payload width; the PE configure word is DATA_W+1 bits wide.
REQ-002 Parameter TIMEOUT, 1023, maximum idle cycles allowed while waiting for a payload word.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  pulse that begins loading one configuration program.
REQ-006 cfg_in_valid  input  1  upstream word valid.
REQ-007 cfg_in_data  input  DATA_W  upstream word, either a header or a payload word.
REQ-008 cfg_in_ready  output  1  sequencer accepts cfg_in_data this cycle.
REQ-009 PE0_Configure_Inport  output  DATA_W+1  PE0 configure port: bit DATA_W is the valid flag, bits [DATA_W-1:0] are the payload.
REQ-010 PE1_Configure_Inport  output  DATA_W+1  PE1 configure port, same format as PE0.
REQ-011 PE2_Configure_Inport  output  DATA_W+1  PE2 configure port, same format as PE0.
REQ-012 busy  output  1  a program is being loaded.
REQ-013 done  output  1  one-cycle pulse at program end.
REQ-014 err  output  1  sticky timeout flag, cleared by the next accepted start.
REQ-015 words_total  output  16  payload words delivered in the current or last program.

Function
REQ-016 Header word fields:
- [31:24] = payload count N.
- [1:0] = destination: 0 = PE0, 1 = PE1, 2 = PE2, 3 = broadcast to all three.
- All other bits are ignored.
REQ-017 FSM states are IDLE, HDR, PAY and DONE; a transfer is the condition cfg_in_valid & cfg_in_ready.
REQ-018 IDLE: cfg_in_ready=0, busy=0; start -> HDR, clear err, clear words_total.
REQ-019 HDR: cfg_in_ready=1, busy=1.
- On a transfer with N>0: latch N and the destination, go to PAY.
- On a transfer with N=0: go to DONE.
REQ-020 PAY: cfg_in_ready=1, busy=1.
- Each transfer forwards the word, decrements the remaining count and increments words_total.
- After the Nth word, go to HDR.
REQ-021 DONE lasts exactly one cycle: done=1, busy=1, cfg_in_ready=0, then IDLE.
REQ-022 Output timing for a payload word transferred in cycle t:
- In cycle t+1 the destination port(s) show {1'b1, word}.
- Bits [DATA_W-1:0] hold that word until the next word for that port.
- The valid bit returns to 0 in cycle t+2 unless another word for that port transfers in cycle t+1.
REQ-023 Back-to-back transfers produce one valid beat per cycle with no bubbles; throughput is one word per cycle.
REQ-024 Header words never appear on any PE port.
REQ-025 Broadcast writes the identical word and valid beat to all three ports in the same cycle; words_total counts it once.
REQ-026 Timeout:
- The idle counter counts PAY cycles without a transfer and resets on every transfer.
- When it reaches TIMEOUT: set err=1, drop the remaining words, go to IDLE with no done pulse.
REQ-027 start is ignored whenever the FSM is not in IDLE.
REQ-028 words_total saturates at 16'hFFFF.
REQ-029 A start arriving in the same cycle as the DONE->IDLE transition is ignored; a start is accepted only while the FSM is in IDLE.

Reset
REQ-030 On reset low, asynchronously:
- FSM=IDLE; all three configure ports = 0.
- cfg_in_ready=0, busy=0, done=0, err=0, words_total=0.
- Counters = 0.
REQ-031 Reset asserted mid-PAY aborts the program; after release the block waits in IDLE for a new start and keeps no partial state.

Verification
REQ-032 Reset release, no start -> all outputs 0 and cfg_in_ready=0 for 20 cycles.
REQ-033 start, then headers and payload streamed back-to-back:
- Stimulus: header 0x02000000 (N=2, PE0), words 8 and 9; header 0x01000001 (N=1, PE1), word 12; header 0x00000000 (end).
- PE0 ports: {1,8} then {1,9} on consecutive cycles.
- PE1 port: {1,12}.
- Ends with done pulsed once, words_total=3, busy=0.
REQ-034 Broadcast header 0x01000003 with word 0x5 -> all three ports show {1,5} in the same cycle; words_total=1.
REQ-035 Header N=3 for PE2; first word delivered, cfg_in_valid then held low for TIMEOUT cycles:
- err=1, FSM in IDLE, no done pulse.
- A following start clears err.
REQ-036 Two scenarios:
- Reset pulsed low during PAY -> all outputs 0 immediately.
- A fresh program after reset loads correctly.
REQ-037 cfg_in_valid toggled randomly during a 10-word PE1 program -> exactly 10 valid beats on PE1 in input order; no beats appear on PE0 or PE2.
